// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer and the ALU it drives:
// sequencer state encoding, op-code constants and the stage LED decode.
package alu_pkg;

    localparam int OPW = 3;

    // Sequencer states. The enum fixes the encoding that the sequencer's
    // state constants are built from.
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } seq_state_t;

    // Op-codes understood by the ALU.
    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_NOT = 3'b010;
    localparam logic [OPW-1:0] OP_AND = 3'b011;
    localparam logic [OPW-1:0] OP_OR  = 3'b100;
    localparam logic [OPW-1:0] OP_XOR = 3'b101;
    localparam logic [OPW-1:0] OP_LT  = 3'b110;
    localparam logic [OPW-1:0] OP_EQ  = 3'b111;

    // One-hot prompt LEDs: A, B, op; dark while executing / showing.
    function automatic logic [2:0] stage_leds(input logic [2:0] st);
        logic [2:0] leds;
        leds = 3'b000;
        case (st)
            S_A:     leds = 3'b001;
            S_B:     leds = 3'b010;
            S_OP:    leds = 3'b100;
            default: leds = 3'b000;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Bus between the command sequencer (master) and the ALU (slave): the
// registered operands/op-code going out and the combinational result
// and flags coming back.
interface alu_cmd_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_ctrl;
    logic [WIDTH-1:0] alu_res;
    logic             alu_car;
    logic             alu_of;

    modport master (
        output alu_a,
        output alu_b,
        output alu_ctrl,
        input  alu_res,
        input  alu_car,
        input  alu_of
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_ctrl,
        output alu_res,
        output alu_car,
        output alu_of
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter that
// accepts a level change only after DEBOUNCE_CYCLES consecutive differing
// samples, and a rising-edge detector giving one pulse per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    // Wide enough to hold DEBOUNCE_CYCLES-1, the largest value reached
    // before the counter is cleared, so it never wraps while differing.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             deb;
    logic             deb_p;

    // Synchronize the raw button, count stable differing cycles, and
    // remember the previous debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            deb     <= 1'b0;
            deb_p   <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            deb_p   <= deb;
            if (sync_p1 != deb) begin
                if (cnt == CNT_LAST) begin
                    deb <= sync_p1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press_pulse = deb & ~deb_p;

endmodule

// File: rtl/alu_cmd_seq.sv
// Operand/command sequencer in front of the ALU. One debounced enter press
// per field captures A, B and the op-code from the switches; the ALU result
// and flags are latched one cycle later and held for display until the next
// A entry. A clear press, or reset, abandons the sequence and zeroes it.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_enter,
    input  logic             btn_clear,
    alu_cmd_seq_if.master    alu,
    output logic [WIDTH-1:0] res_q,
    output logic             car_q,
    output logic             of_q,
    output logic             res_valid,
    output logic [2:0]       stage
);

    // State constants, encodings taken from seq_state_t.
    localparam logic [2:0] ST_A    = S_A;
    localparam logic [2:0] ST_B    = S_B;
    localparam logic [2:0] ST_OP   = S_OP;
    localparam logic [2:0] ST_EXEC = S_EXEC;
    localparam logic [2:0] ST_SHOW = S_SHOW;

    logic             ent_pulse;
    logic             clr_pulse;
    logic [2:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] res_r;
    logic             car_r;
    logic             of_r;
    logic             valid_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_enter (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_enter),
        .press_pulse(ent_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_clear),
        .press_pulse(clr_pulse)
    );

    // Sequencer FSM with operand and result capture; clear overrides any
    // enter pulse arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_r   <= '0;
            car_r   <= 1'b0;
            of_r    <= 1'b0;
            valid_r <= 1'b0;
        end else if (clr_pulse) begin
            state_q <= ST_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_r   <= '0;
            car_r   <= 1'b0;
            of_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_q)
                ST_A: begin
                    if (ent_pulse) begin
                        a_q     <= sw;
                        valid_r <= 1'b0;
                        state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (ent_pulse) begin
                        b_q     <= sw;
                        state_q <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (ent_pulse) begin
                        op_q    <= sw[OPW-1:0];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable on the ALU for a full cycle.
                    res_r   <= alu.alu_res;
                    car_r   <= alu.alu_car;
                    of_r    <= alu.alu_of;
                    valid_r <= 1'b1;
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (ent_pulse) begin
                        state_q <= ST_A;
                    end
                end
                default: state_q <= ST_A;
            endcase
        end
    end

    assign alu.alu_a    = a_q;
    assign alu.alu_b    = b_q;
    assign alu.alu_ctrl = op_q;
    assign res_q        = res_r;
    assign car_q        = car_r;
    assign of_q         = of_r;
    assign res_valid    = valid_r;
    assign stage        = stage_leds(state_q);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq with a behavioural 4-bit ALU beside it. Button
// presses update a field-level reference model; expected results go into a
// scoreboard queue drained by a monitor whenever res_valid rises.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    localparam int W  = 4;
    localparam int DC = 4;

    typedef struct {
        logic [3:0] res;
        logic       car;
        logic       of;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         btn_enter;
    logic         btn_clear;
    logic [W-1:0] res_q;
    logic         car_q;
    logic         of_q;
    logic         res_valid;
    logic [2:0]   stage;

    int checks = 0;
    int errors = 0;

    exp_t sbq[$];

    // Reference model: which field the next enter fills, and field values.
    int         m_fidx;
    logic [3:0] m_a, m_b, m_res;
    logic [2:0] m_op;
    logic       m_car, m_of, m_valid;

    alu_cmd_seq_if #(.WIDTH(W)) alu_bus ();

    alu_cmd_seq #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .alu      (alu_bus),
        .res_q    (res_q),
        .car_q    (car_q),
        .of_q     (of_q),
        .res_valid(res_valid),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    // 4-bit ALU: returns {res, carry, overflow}.
    function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       o;
        s = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                        o = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                        o = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = {3'b000, ($signed(a) < $signed(b))};
            default: r = {3'b000, (a == b)};
        endcase
        return {r, c, o};
    endfunction

    always_comb begin
        {alu_bus.alu_res, alu_bus.alu_car, alu_bus.alu_of} =
            alu_fn(alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_ctrl);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fidx = 0; m_a = '0; m_b = '0; m_op = '0;
        m_res = '0; m_car = 1'b0; m_of = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_press(input bit clr, input bit ent, input logic [3:0] val);
        logic [5:0] r;
        if (clr) begin
            model_reset();
        end else if (ent) begin
            case (m_fidx)
                0: begin m_a = val; m_valid = 1'b0; m_fidx = 1; end
                1: begin m_b = val; m_fidx = 2; end
                2: begin
                    m_op = val[2:0];
                    r = alu_fn(m_a, m_b, m_op);
                    m_res = r[5:2]; m_car = r[1]; m_of = r[0]; m_valid = 1'b1;
                    sbq.push_back('{res: m_res, car: m_car, of: m_of});
                    m_fidx = 3;
                end
                default: m_fidx = 0;
            endcase
        end
    endtask

    task automatic check_state(input string tag);
        logic [2:0] st;
        case (m_fidx)
            0: st = 3'b001;
            1: st = 3'b010;
            2: st = 3'b100;
            default: st = 3'b000;
        endcase
        chk({tag, "_stage"}, stage, st);
        chk({tag, "_alu_a"}, alu_bus.alu_a, m_a);
        chk({tag, "_alu_b"}, alu_bus.alu_b, m_b);
        chk({tag, "_alu_ctrl"}, alu_bus.alu_ctrl, m_op);
        chk({tag, "_res_q"}, res_q, m_res);
        chk({tag, "_car_q"}, car_q, m_car);
        chk({tag, "_of_q"}, of_q, m_of);
        chk({tag, "_res_valid"}, res_valid, m_valid);
    endtask

    // Clean press of enter and/or clear, then a clean release.
    task automatic press(input bit clr, input bit ent, input logic [3:0] val,
                         input int hold, input int rel, input bit chk_exec);
        bit seen;
        seen = 1'b0;
        model_press(clr, ent, val);
        @(negedge clk);
        sw = val; btn_enter = ent; btn_clear = clr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (chk_exec && !seen && stage == 3'b000) begin
                seen = 1'b1;
                chk("exec_valid_first_edge", res_valid, 0);
                @(negedge clk);
                i++;
                chk("exec_valid_second_edge", res_valid, 1);
            end
        end
        if (chk_exec) chk("exec_reached", seen, 1);
        btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    // Scoreboard monitor: each rising res_valid must match the oldest expectation.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && !prev_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_pending actual=result required=no_result res_q=%0d", res_q);
            end else begin
                e = sbq.pop_front();
                chk("sb_res_q", res_q, e.res);
                chk("sb_car_q", car_q, e.car);
                chk("sb_of_q", of_q, e.of);
                chk("sb_stage", stage, 3'b000);
            end
        end
        prev_valid = res_valid;
    end

    initial begin
        int lvl[6];
        int len[6];
        int ups;
        logic [2:0] prev_stage;
        lvl = '{1, 0, 1, 0, 1, 0};
        len = '{3, 3, 3, 3, 10, 10};

        rst_n = 1'b0; sw = '0; btn_enter = 1'b0; btn_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (20) @(negedge clk);
        check_state("reset");

        // 3 + 5 with ADD.
        press(0, 1, 4'b0011, 10, 10, 0);
        press(0, 1, 4'b0101, 10, 10, 0);
        press(0, 1, 4'b0000, 10, 10, 1);
        chk("add_res_q", res_q, 4'b1000);
        chk("add_car_q", car_q, 0);
        chk("add_of_q", of_q, 1);
        chk("add_res_valid", res_valid, 1);
        chk("add_stage", stage, 3'b000);
        check_state("add");

        // Leave S_SHOW, then a bouncy press for A.
        press(0, 1, 4'b0000, 10, 10, 0);
        check_state("show_exit");
        model_press(0, 1, 4'b1001);
        ups = 0;
        prev_stage = stage;
        sw = 4'b1001;
        for (int j = 0; j < 6; j++) begin
            btn_enter = lvl[j][0];
            for (int k = 0; k < len[j]; k++) begin
                @(negedge clk);
                if (prev_stage == 3'b001 && stage == 3'b010) ups++;
                prev_stage = stage;
            end
        end
        chk("bounce_advances", ups, 1);
        check_state("bounce");

        // Enter held 50 cycles from S_A, switches changing mid-hold.
        press(1, 0, 4'b0000, 10, 10, 0);
        model_press(0, 1, 4'b0110);
        @(negedge clk);
        sw = 4'b0110; btn_enter = 1'b1;
        repeat (20) @(negedge clk);
        sw = 4'b1010;
        repeat (30) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        check_state("long_hold");

        // Clear and enter together in S_OP.
        press(1, 0, 4'b0000, 10, 10, 0);
        press(0, 1, 4'b0111, 10, 10, 0);
        press(0, 1, 4'b0001, 10, 10, 0);
        check_state("in_op");
        press(1, 1, 4'b0011, 10, 10, 0);
        chk("clr_ent_stage", stage, 3'b001);
        chk("clr_ent_alu_a", alu_bus.alu_a, 0);
        chk("clr_ent_alu_b", alu_bus.alu_b, 0);
        chk("clr_ent_valid", res_valid, 0);
        check_state("clr_ent");

        // Reset while showing a result.
        press(0, 1, 4'b0011, 10, 10, 0);
        press(0, 1, 4'b0101, 10, 10, 0);
        press(0, 1, 4'b0000, 10, 10, 0);
        chk("pre_rst_res_q", res_q, 4'b1000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_res_q", res_q, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_stage", stage, 3'b001);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_state("post_rst");

        // Random sequences of enter and clear presses.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0)
                press(1, 0, 4'($urandom_range(0, 15)), $urandom_range(6, 14),
                      $urandom_range(7, 14), 0);
            else
                press(0, 1, 4'($urandom_range(0, 15)), $urandom_range(6, 14),
                      $urandom_range(7, 14), 0);
            check_state("rand");
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Operand/command sequencer that sits directly upstream of the 4-bit ALU and captures its result. It steps the user through entering operand A, operand B and the 3-bit operation code from board switches, one debounced "enter" press per field. It presents the captured fields to the ALU, registers the ALU's result and flags one cycle later, and holds them for display until the next sequence starts.

## Interface
- `WIDTH`, default 4: operand / result width.
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required to accept a button level change; must be ≥ 2.
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw` in WIDTH: raw switch value; sampled only on an accepted enter press.
- `btn_enter` in 1: raw, bouncy, active-high enter button.
- `btn_clear` in 1: raw, bouncy, active-high clear button.
- `alu_a` out WIDTH: registered operand A to the ALU.
- `alu_b` out WIDTH: registered operand B to the ALU.
- `alu_ctrl` out 3: registered operation code to the ALU.
- `alu_res` in WIDTH: ALU result; combinational from `alu_a`/`alu_b`/`alu_ctrl`.
- `alu_car` in 1: ALU carry flag.
- `alu_of` in 1: ALU overflow flag.
- `res_q` out WIDTH: latched result.
- `car_q` out 1: latched carry flag.
- `of_q` out 1: latched overflow flag.
- `res_valid` out 1: high while `res_q`/`car_q`/`of_q` hold a result from the current sequence.
- `stage` out 3: one-hot prompt for LEDs. 001 = enter A, 010 = enter B, 100 = enter op, 000 = exec/show.

## Operation
- Both buttons pass through a `btn_debounce` instance:
  - 2-flop synchronizer, then a stability counter, then a rising-edge detector.
  - Output is a 1-cycle pulse per accepted press.
- FSM states: `S_A` (reset state), `S_B`, `S_OP`, `S_EXEC`, `S_SHOW`.
- `S_A`: on enter pulse, `a_q <= sw`, clear `res_valid`, go to `S_B`.
- `S_B`: on enter pulse, `b_q <= sw`, go to `S_OP`.
- `S_OP`: on enter pulse, `op_q <= sw[2:0]`, go to `S_EXEC`. When WIDTH > 3, upper switch bits are ignored.
- `S_EXEC`: unconditional single cycle. At its end, `res_q <= alu_res`, `car_q <= alu_car`, `of_q <= alu_of`, `res_valid <= 1`. Go to `S_SHOW`.
- `S_SHOW`: hold all outputs. On enter pulse, go to `S_A`. `res_q`/flags stay visible; `res_valid` drops on the next accepted A entry.
- Clear pulse in any state:
  - Go to `S_A`.
  - Zero `a_q`, `b_q`, `op_q`, `res_q`, `car_q`, `of_q`, `res_valid`.
- Enter and clear pulses in the same cycle: clear wins, enter is discarded.
- `alu_a`/`alu_b`/`alu_ctrl` are direct outputs of `a_q`/`b_q`/`op_q`. They change only at the capture edges.
- Holding enter produces exactly one pulse. The next pulse needs a release accepted by the debouncer, then a new press.
- Reset values: every output 0, except `stage` = 001. Debouncer state: synchronizers 0, counters 0, debounced level 0.

## Timing
- Debounce rule:
  - If `sync != deb`, `cnt <= cnt + 1`.
  - When `cnt == DEBOUNCE_CYCLES-1` and still differing, `deb <= sync` and `cnt <= 0`.
  - If `sync == deb`, `cnt <= 0`.
- Debounce latency: a clean press held from edge t yields an enter pulse in cycle t + 2 + DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Capture into `a_q`/`b_q`/`op_q` happens on the edge ending the pulse cycle.
- The `S_OP` pulse edge loads `op_q`. `S_EXEC` lasts exactly one cycle. `res_q` and `res_valid` update on the edge ending `S_EXEC`. Total: 2 edges after the op pulse.
- `rst_n` deassertion is synchronous to `clk` at system level. Assertion mid-sequence returns to `S_A` immediately, with no partial result retained.
- Counter width: $clog2(DEBOUNCE_CYCLES). It must not wrap while `sync != deb`.

## Structure
- Shared package `alu_pkg`:
  - FSM state enum `seq_state_t`.
  - Op-code constants ADD=000, SUB=001, NOT=010, AND=011, OR=100, XOR=101, LT=110, EQ=111, shared with the ALU.
  - `OPW = 3`.
- One sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `btn_raw`, `press_pulse`), instantiated twice.
- The top contains the FSM, operand registers and result registers. The ALU is instantiated beside it by the board top, not inside it.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4 and the real ALU.
- Reset, then idle 20 cycles -> `stage` = 001, all other outputs 0, `res_valid` = 0.
- Enter A = 0011, B = 0101, op = 000, each press held 10 cycles -> 2 edges after the op pulse: `res_q` = 1000, `car_q` = 0, `of_q` = 1, `res_valid` = 1, `stage` = 000.
- Enter press with 3-cycle bounce pulses before a stable 10-cycle hold -> exactly one A capture; `stage` goes from 001 to 010 once.
- Enter held 50 cycles in `S_A` -> single advance to `S_B`; `b_q` not loaded.
- In `S_OP` with A = 0111, B = 0001: assert clear and enter together -> `stage` = 001, `alu_a` = `alu_b` = 0, `res_valid` = 0.
- Drive `rst_n` low during `S_SHOW` holding `res_q` = 1000 -> same cycle: `res_q` = 0, `res_valid` = 0, `stage` = 001.
